// File: rtl/z80_uart_bridge_pkg.sv
// Purpose : shared constants for the Z80 serial-console bridge (status bit map, default addresses).
// Latency : n/a (package).
// Backpressure: n/a (package).
package z80_uart_pkg;

    // Status register bit positions.
    localparam int ST_TX_FULL  = 0;
    localparam int ST_RX_AVAIL = 1;
    localparam int ST_TX_EMPTY = 2;
    localparam int ST_RX_OVR   = 3;
    localparam int ST_TX_OVF   = 4;

    // Default CPU addresses of the two registers.
    localparam logic [15:0] DEF_STATUS_ADDR = 16'hfffd;
    localparam logic [15:0] DEF_DATA_ADDR   = 16'hffff;

    // Default FIFO address widths (16 entries each).
    localparam int DEF_TX_AW = 4;
    localparam int DEF_RX_AW = 4;

    // Assemble the status byte; upper three bits read as zero.
    function automatic logic [7:0] pack_status(
        input logic tx_full,
        input logic rx_avail,
        input logic tx_empty,
        input logic rx_ovr,
        input logic tx_ovf
    );
        logic [7:0] st;
        st              = 8'h00;
        st[ST_TX_FULL]  = tx_full;
        st[ST_RX_AVAIL] = rx_avail;
        st[ST_TX_EMPTY] = tx_empty;
        st[ST_RX_OVR]   = rx_ovr;
        st[ST_TX_OVF]   = tx_ovf;
        return st;
    endfunction

endpackage

// File: rtl/z80_uart_bridge_if.sv
// Purpose : bundles the Z80 bus cycle signals and the TX/RX byte streams of the console bridge.
// Latency : n/a (wiring only).
// Backpressure: tx_valid/tx_ready on the TX stream; RX stream is a strobe with no backpressure.
// Ports   : master = CPU/transceiver side, slave = bridge side.
interface z80_uart_bridge_if;
    logic        mreq_n;
    logic        rd_n;
    logic        wr_n;
    logic [15:0] addr;
    logic [7:0]  bus_di;
    logic [7:0]  bus_do;
    logic        bus_sel;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;

    modport master (
        output mreq_n, rd_n, wr_n, addr, bus_di, tx_ready, rx_data, rx_valid,
        input  bus_do, bus_sel, tx_data, tx_valid
    );

    modport slave (
        input  mreq_n, rd_n, wr_n, addr, bus_di, tx_ready, rx_data, rx_valid,
        output bus_do, bus_sel, tx_data, tx_valid
    );
endinterface

// File: rtl/z80_uart_bridge_fifo.sv
// Purpose : synchronous byte FIFO, 2^AW entries, first-word fall-through head.
// Latency : a pushed byte is visible on head the cycle after the push edge.
// Backpressure: push to full is ignored unless a pop is honoured in the same cycle; pop of empty ignored.
// Ports   : clk, resetn (sync, active-low), push/push_dat, pop, head, full, empty.
module byte_fifo #(
    parameter int AW = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       push,
    input  logic [7:0] push_dat,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);
    localparam int DEPTH = 1 << AW;

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_pop;
    logic        do_push;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_pop  = pop & ~empty;
    // When full, a simultaneous pop frees the very slot being written.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    assign head = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/z80_uart_bridge.sv
// Purpose : Z80 bus responder for the serial console: STATUS/DATA decode, TX and RX byte FIFOs, sticky overflow flags.
// Latency : CPU write reaches tx_valid 1 clk after the push edge; rx byte readable 1 clk after its strobe.
// Backpressure: TX drains on tx_valid&tx_ready; writes to a full TX FIFO and strobes into a full RX FIFO are dropped and flagged.
// Ports   : clk, resetn (sync, active-low), bus (z80_uart_bridge_if.slave), int_n.
// Config  : Z80_UART_BRIDGE_IRQ_EN enables the registered int_n output; otherwise int_n is tied high.
module z80_uart_bridge
    import z80_uart_pkg::*;
#(
    parameter int          TX_AW       = DEF_TX_AW,
    parameter int          RX_AW       = DEF_RX_AW,
    parameter logic [15:0] STATUS_ADDR = DEF_STATUS_ADDR,
    parameter logic [15:0] DATA_ADDR   = DEF_DATA_ADDR
) (
    input  logic                clk,
    input  logic                resetn,
    z80_uart_bridge_if.slave    bus,
    output logic                int_n
);
    logic       bus_armed;
    logic       wsel, rsel_d, rsel_s;
    logic       wsel_q, rsel_d_q, rsel_s_q;
    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] tx_head, rx_head;
    logic       tx_ovf, rx_ovr;
    logic       tx_ovf_set, rx_ovr_set, st_clr;
    logic [7:0] status;
    logic [7:0] bus_do_c;

    // After reset the decoder stays blind until the CPU drops mreq, so a
    // cycle already in flight across reset can never push or pop.
    always_ff @(posedge clk) begin
        if (!resetn)         bus_armed <= 1'b0;
        else if (bus.mreq_n) bus_armed <= 1'b1;
    end

    assign wsel   = bus_armed & ~bus.mreq_n & ~bus.wr_n & (bus.addr == DATA_ADDR);
    assign rsel_d = bus_armed & ~bus.mreq_n & ~bus.rd_n & (bus.addr == DATA_ADDR);
    assign rsel_s = bus_armed & ~bus.mreq_n & ~bus.rd_n & (bus.addr == STATUS_ADDR);

    // One push per write cycle however long wr_n is held.
    assign tx_push = wsel & ~wsel_q;
    assign tx_pop  = ~tx_empty & bus.tx_ready;

    // RX pops when the CPU finishes the read, so bus_do stays stable throughout it.
    assign rx_pop  = rsel_d_q & ~rsel_d & ~rx_empty;
    assign rx_push = bus.rx_valid;

    assign tx_ovf_set = tx_push & tx_full & ~tx_pop;
    assign rx_ovr_set = bus.rx_valid & rx_full & ~rx_pop;
    assign st_clr     = rsel_s_q & ~rsel_s;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wsel_q   <= 1'b0;
            rsel_d_q <= 1'b0;
            rsel_s_q <= 1'b0;
            tx_ovf   <= 1'b0;
            rx_ovr   <= 1'b0;
        end else begin
            wsel_q   <= wsel;
            rsel_d_q <= rsel_d;
            rsel_s_q <= rsel_s;
            // A fresh overflow in the clearing cycle keeps the flag set.
            tx_ovf   <= tx_ovf_set | (tx_ovf & ~st_clr);
            rx_ovr   <= rx_ovr_set | (rx_ovr & ~st_clr);
        end
    end

    byte_fifo #(.AW(TX_AW)) u_tx_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (tx_push),
        .push_dat (bus.bus_di),
        .pop      (tx_pop),
        .head     (tx_head),
        .full     (tx_full),
        .empty    (tx_empty)
    );

    byte_fifo #(.AW(RX_AW)) u_rx_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (rx_push),
        .push_dat (bus.rx_data),
        .pop      (rx_pop),
        .head     (rx_head),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    assign status = pack_status(tx_full, ~rx_empty, tx_empty, rx_ovr, tx_ovf);

    always_comb begin
        bus_do_c = 8'h00;
        if (rsel_d) begin
            if (!rx_empty) bus_do_c = rx_head;
        end else if (rsel_s) begin
            bus_do_c = status;
        end
    end

    assign bus.bus_do   = bus_do_c;
    assign bus.bus_sel  = rsel_d | rsel_s;
    assign bus.tx_data  = tx_head;
    assign bus.tx_valid = ~tx_empty;

`ifdef Z80_UART_BRIDGE_IRQ_EN
    logic int_n_q;
    // Follows the RX empty flag one clk later.
    always_ff @(posedge clk) begin
        if (!resetn) int_n_q <= 1'b1;
        else         int_n_q <= rx_empty;
    end
    assign int_n = int_n_q;
`else
    assign int_n = 1'b1;
`endif

endmodule

// File: tb/tb_z80_uart_bridge.sv
// Purpose : self-checking bench for z80_uart_bridge; queue-level reference model plus decoupled read/TX monitor.
// Latency : n/a.
// Backpressure: tx_ready driven by the bench; held low while the model accumulates TX bytes.
module tb_z80_uart_bridge;
    import z80_uart_pkg::*;

    localparam logic [15:0] SA = DEF_STATUS_ADDR;
    localparam logic [15:0] DA = DEF_DATA_ADDR;

    logic clk;
    logic resetn;
    logic int_n;

    z80_uart_bridge_if bif ();

    z80_uart_bridge dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bif),
        .int_n  (int_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: plain queues of bytes with 16-entry capacity.
    logic [7:0] m_tx[$];
    logic [7:0] m_rx[$];
    logic [7:0] exp_rd[$];
    bit         m_tx_ovf = 1'b0;
    bit         m_rx_ovr = 1'b0;
    bit         sel_prev = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] model_status();
        logic [7:0] s;
        s = 8'h00;
        s[0] = (m_tx.size() == 16);
        s[1] = (m_rx.size() != 0);
        s[2] = (m_tx.size() == 0);
        s[3] = m_rx_ovr;
        s[4] = m_tx_ovf;
        return s;
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input int hold);
        if (a == DA) begin
            if (m_tx.size() < 16) m_tx.push_back(d);
            else m_tx_ovf = 1'b1;
        end
        bif.addr = a; bif.bus_di = d; bif.mreq_n = 1'b0; bif.wr_n = 1'b0;
        cyc(hold);
        bif.wr_n = 1'b1; bif.mreq_n = 1'b1;
        cyc(1);
    endtask

    task automatic cpu_read(input logic [15:0] a, input int hold);
        if (a == DA) begin
            if (m_rx.size() != 0) exp_rd.push_back(m_rx.pop_front());
            else exp_rd.push_back(8'h00);
        end else begin
            exp_rd.push_back(model_status());
            m_tx_ovf = 1'b0;
            m_rx_ovr = 1'b0;
        end
        bif.addr = a; bif.mreq_n = 1'b0; bif.rd_n = 1'b0;
        cyc(hold);
        bif.rd_n = 1'b1; bif.mreq_n = 1'b1;
        cyc(1);
    endtask

    task automatic rx_strobe(input logic [7:0] d);
        if (m_rx.size() < 16) m_rx.push_back(d);
        else m_rx_ovr = 1'b1;
        bif.rx_data = d; bif.rx_valid = 1'b1;
        cyc(1);
        bif.rx_valid = 1'b0;
    endtask

    task automatic drain_tx();
        bif.tx_ready = 1'b1;
        for (int i = 0; i < 200 && bif.tx_valid; i++) cyc(1);
        bif.tx_ready = 1'b0;
        chk("tx_drained", 8'(bif.tx_valid), 8'h00);
        cyc(1);
    endtask

    task automatic chk_int(input string name, input bit low_expected);
`ifdef Z80_UART_BRIDGE_IRQ_EN
        chk(name, 8'(int_n), low_expected ? 8'h00 : 8'h01);
`else
        chk(name, 8'(int_n), 8'h01);
`endif
    endtask

    // Monitor: compares each new read cycle and each TX handshake against the model.
    always @(negedge clk) begin
        if (bif.bus_sel && !sel_prev) begin
            if (exp_rd.size() == 0) begin
                n_chk++;
                $display("FAIL rd_unexpected: got %02h expected no read", bif.bus_do);
            end else begin
                chk("rd_data", bif.bus_do, exp_rd.pop_front());
            end
        end
        sel_prev = bif.bus_sel;
        if (resetn && bif.tx_valid && bif.tx_ready) begin
            if (m_tx.size() == 0) begin
                n_chk++;
                $display("FAIL tx_unexpected: got %02h expected no byte", bif.tx_data);
            end else begin
                chk("tx_data", bif.tx_data, m_tx.pop_front());
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        resetn = 1'b0;
        bif.mreq_n = 1'b1; bif.rd_n = 1'b1; bif.wr_n = 1'b1;
        bif.addr = 16'h0000; bif.bus_di = 8'h00;
        bif.tx_ready = 1'b0; bif.rx_data = 8'h00; bif.rx_valid = 1'b0;
        cyc(3);

        // 1. reset state
        chk("rst_tx_valid", 8'(bif.tx_valid), 8'h00);
        chk("rst_bus_sel", 8'(bif.bus_sel), 8'h00);
        chk("rst_bus_do", bif.bus_do, 8'h00);
        chk("rst_int_n", 8'(int_n), 8'h01);
        resetn = 1'b1;
        cyc(2);
        cpu_read(SA, 2);
        chk("t1_tx_valid", 8'(bif.tx_valid), 8'h00);
        chk_int("t1_int_n", 1'b0);

        // 2. long write strobe pushes once
        cpu_write(DA, 8'h41, 3);
        chk("t2_tx_valid", 8'(bif.tx_valid), 8'h01);
        chk("t2_tx_head", bif.tx_data, 8'h41);
        bif.tx_ready = 1'b1;
        cyc(1);
        bif.tx_ready = 1'b0;
        cyc(1);
        cpu_read(SA, 2);
        chk("t2_tx_empty", 8'(bif.tx_valid), 8'h00);

        // 3. TX overflow
        for (int i = 0; i < 16; i++) cpu_write(DA, 8'($urandom), $urandom_range(1, 3));
        cpu_read(SA, 2);
        cpu_write(DA, 8'($urandom), 1);
        cpu_read(SA, 2);
        drain_tx();
        cpu_read(SA, 1);

        // 4. single RX byte
        rx_strobe(8'h5A);
        cyc(1);
        chk_int("t4_int_low", 1'b1);
        cpu_read(SA, 2);
        cpu_read(DA, 2);
        cyc(1);
        chk_int("t4_int_high", 1'b0);
        cpu_read(SA, 2);

        // 5. RX overflow and empty read
        for (int i = 0; i < 17; i++) rx_strobe(8'($urandom));
        cpu_read(SA, 2);
        for (int i = 0; i < 16; i++) cpu_read(DA, $urandom_range(1, 3));
        cpu_read(DA, 2);
        cpu_read(SA, 2);

        // 6. full RX with simultaneous pop and strobe
        for (int i = 0; i < 16; i++) rx_strobe(8'($urandom));
        b = 8'($urandom);
        exp_rd.push_back(m_rx.pop_front());
        m_rx.push_back(b);
        bif.addr = DA; bif.mreq_n = 1'b0; bif.rd_n = 1'b0;
        cyc(2);
        bif.rd_n = 1'b1; bif.mreq_n = 1'b1;
        bif.rx_data = b; bif.rx_valid = 1'b1;
        cyc(1);
        bif.rx_valid = 1'b0;
        cyc(1);
        cpu_read(SA, 2);
        for (int i = 0; i < 16; i++) cpu_read(DA, 1);

        // reset in the middle of a write cycle
        for (int i = 0; i < 3; i++) rx_strobe(8'($urandom));
        bif.addr = DA; bif.bus_di = 8'($urandom); bif.mreq_n = 1'b0; bif.wr_n = 1'b0;
        cyc(1);
        resetn = 1'b0;
        cyc(2);
        resetn = 1'b1;
        m_tx.delete(); m_rx.delete(); m_tx_ovf = 1'b0; m_rx_ovr = 1'b0;
        cyc(3);
        chk("rst_mid_no_push", 8'(bif.tx_valid), 8'h00);
        bif.wr_n = 1'b1; bif.mreq_n = 1'b1;
        cyc(2);
        cpu_read(SA, 2);
        cpu_read(DA, 1);

        // random mix with TX held off
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 4))
                0: cpu_write(DA, 8'($urandom), $urandom_range(1, 3));
                1: cpu_write(SA, 8'($urandom), 1);
                2: rx_strobe(8'($urandom));
                3: cpu_read(DA, $urandom_range(1, 3));
                default: cpu_read(SA, $urandom_range(1, 2));
            endcase
        end
        drain_tx();
        cpu_read(SA, 2);

        cyc(3);
        chk("exp_rd_left", 8'(exp_rd.size()), 8'h00);
        chk("tx_left", 8'(m_tx.size()), 8'h00);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
